// File: rtl/jzjpcc_hazard_control_pkg.sv
// Shared types for the jzjpcc hazard controller: forwarding selects,
// scoreboard slot layout and the load-use FSM state.
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    REGFILE = 2'b00,
    MEM     = 2'b01,
    WB      = 2'b10
  } forward_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rdAddr;
    logic       rdWriteEnable;
    logic       isLoad;
  } scoreboard_slot_t;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hazard_state_t;

  localparam scoreboard_slot_t SLOT_EMPTY = '0;

  // Newest producer wins: a hit in E (memory next cycle) beats a hit in M.
  function automatic forward_sel_t resolve_fwd(input logic hit_e, input logic hit_m);
    if (hit_e) return MEM;
    else if (hit_m) return WB;
    else return REGFILE;
  endfunction

endpackage

// File: rtl/jzjpcc_hazard_match.sv
// Compares one decode source register against one scoreboard slot.
// x0, unused sources, bubbles and non-writing producers never match.
module jzjpcc_hazard_match
  import jzjpcc_pkg::*;
(
  input  logic [4:0]       rs_addr_i,
  input  logic             rs_used_i,
  input  scoreboard_slot_t slot_i,
  output logic             match_o
);

  logic unused_is_load;
  assign unused_is_load = slot_i.isLoad;

  assign match_o = rs_used_i & slot_i.valid & slot_i.rdWriteEnable &
                   (slot_i.rdAddr == rs_addr_i) & (rs_addr_i != '0);

endmodule

// File: rtl/jzjpcc_hazard_control.sv
// Hazard controller for the five-stage jzjpcc core: E/M/W scoreboard, forwarding
// selects, load-use stalls and branch flushes. Macro JZJPCC_FORWARDING_EN enables forwarding.
module jzjpcc_hazard_control
  import jzjpcc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        decode_valid,
  input  logic [4:0]  decode_rs1Addr,
  input  logic [4:0]  decode_rs2Addr,
  input  logic        decode_rs1Used,
  input  logic        decode_rs2Used,
  input  logic [4:0]  decode_rdAddr,
  input  logic        decode_rdWriteEnable,
  input  logic        decode_isLoad,
  input  logic        execute_branchTaken,
  output logic        stallFetch,
  output logic        stallDecode,
  output logic        flushDecode,
  output logic        bubbleExecute,
  output logic [1:0]  rs1ForwardSel,
  output logic [1:0]  rs2ForwardSel,
  output logic [31:0] perf_stallCycles
);

  scoreboard_slot_t slot_e_q, slot_m_q, slot_w_q, slot_e_d;
  logic [31:0]      perf_q;
  logic             rs1_used, rs2_used;
  logic             rs1_hit_e, rs1_hit_m, rs1_hit_w;
  logic             rs2_hit_e, rs2_hit_m, rs2_hit_w;
  logic             hazard, stall, bubble;

  // An empty decode slot carries no real sources, so it cannot raise a hazard.
  assign rs1_used = decode_valid & decode_rs1Used;
  assign rs2_used = decode_valid & decode_rs2Used;

  jzjpcc_hazard_match u_rs1_e (.rs_addr_i(decode_rs1Addr), .rs_used_i(rs1_used), .slot_i(slot_e_q), .match_o(rs1_hit_e));
  jzjpcc_hazard_match u_rs1_m (.rs_addr_i(decode_rs1Addr), .rs_used_i(rs1_used), .slot_i(slot_m_q), .match_o(rs1_hit_m));
  jzjpcc_hazard_match u_rs1_w (.rs_addr_i(decode_rs1Addr), .rs_used_i(rs1_used), .slot_i(slot_w_q), .match_o(rs1_hit_w));
  jzjpcc_hazard_match u_rs2_e (.rs_addr_i(decode_rs2Addr), .rs_used_i(rs2_used), .slot_i(slot_e_q), .match_o(rs2_hit_e));
  jzjpcc_hazard_match u_rs2_m (.rs_addr_i(decode_rs2Addr), .rs_used_i(rs2_used), .slot_i(slot_m_q), .match_o(rs2_hit_m));
  jzjpcc_hazard_match u_rs2_w (.rs_addr_i(decode_rs2Addr), .rs_used_i(rs2_used), .slot_i(slot_w_q), .match_o(rs2_hit_w));

  // Write-first register file: a W-slot producer is already visible to decode.
  logic unused_w_hits;
  assign unused_w_hits = rs1_hit_w | rs2_hit_w;

`ifdef JZJPCC_FORWARDING_EN
  hazard_state_t state_q;
  forward_sel_t  rs1_sel_q, rs2_sel_q;

  assign hazard = (state_q == RUN) & slot_e_q.isLoad & (rs1_hit_e | rs2_hit_e);
`else
  assign hazard = rs1_hit_e | rs2_hit_e | rs1_hit_m | rs2_hit_m;
`endif

  // A taken branch overrides any stall: the stalled instruction is being discarded.
  assign stall         = hazard & ~execute_branchTaken;
  assign bubble        = stall | execute_branchTaken;
  assign stallFetch    = stall;
  assign stallDecode   = stall;
  assign flushDecode   = execute_branchTaken;
  assign bubbleExecute = bubble;

  always_comb begin
    slot_e_d = SLOT_EMPTY;
    if (decode_valid && !bubble) begin
      slot_e_d.valid         = 1'b1;
      slot_e_d.rdAddr        = decode_rdAddr;
      slot_e_d.rdWriteEnable = decode_rdWriteEnable;
      slot_e_d.isLoad        = decode_isLoad;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_e_q <= SLOT_EMPTY;
      slot_m_q <= SLOT_EMPTY;
      slot_w_q <= SLOT_EMPTY;
      perf_q   <= '0;
    end else begin
      slot_e_q <= slot_e_d;
      slot_m_q <= slot_e_q;
      slot_w_q <= slot_m_q;
      if (stall && (perf_q != '1)) perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stallCycles = perf_q;

`ifdef JZJPCC_FORWARDING_EN
  // stall is already masked by a branch, so a flush always lands in RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      rs1_sel_q <= REGFILE;
      rs2_sel_q <= REGFILE;
    end else begin
      state_q <= stall ? LOAD_STALL : RUN;
      if (slot_e_d.valid) begin
        rs1_sel_q <= resolve_fwd(rs1_hit_e, rs1_hit_m);
        rs2_sel_q <= resolve_fwd(rs2_hit_e, rs2_hit_m);
      end else begin
        rs1_sel_q <= REGFILE;
        rs2_sel_q <= REGFILE;
      end
    end
  end

  assign rs1ForwardSel = rs1_sel_q;
  assign rs2ForwardSel = rs2_sel_q;
`else
  assign rs1ForwardSel = '0;
  assign rs2ForwardSel = '0;
`endif

endmodule

// File: tb/tb_jzjpcc_hazard_control.sv
// Directed bench for jzjpcc_hazard_control; expectations follow JZJPCC_FORWARDING_EN.
module tb_jzjpcc_hazard_control;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        decode_valid = 1'b0;
  logic [4:0]  decode_rs1Addr = '0;
  logic [4:0]  decode_rs2Addr = '0;
  logic        decode_rs1Used = 1'b0;
  logic        decode_rs2Used = 1'b0;
  logic [4:0]  decode_rdAddr = '0;
  logic        decode_rdWriteEnable = 1'b0;
  logic        decode_isLoad = 1'b0;
  logic        execute_branchTaken = 1'b0;
  logic        stallFetch, stallDecode, flushDecode, bubbleExecute;
  logic [1:0]  rs1ForwardSel, rs2ForwardSel;
  logic [31:0] perf_stallCycles;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_perf = '0;
  logic [3:0]  ctrl;
  logic [3:0]  sels;

  assign ctrl = {stallFetch, stallDecode, flushDecode, bubbleExecute};
  assign sels = {rs1ForwardSel, rs2ForwardSel};

  jzjpcc_hazard_control dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .decode_valid        (decode_valid),
    .decode_rs1Addr      (decode_rs1Addr),
    .decode_rs2Addr      (decode_rs2Addr),
    .decode_rs1Used      (decode_rs1Used),
    .decode_rs2Used      (decode_rs2Used),
    .decode_rdAddr       (decode_rdAddr),
    .decode_rdWriteEnable(decode_rdWriteEnable),
    .decode_isLoad       (decode_isLoad),
    .execute_branchTaken (execute_branchTaken),
    .stallFetch          (stallFetch),
    .stallDecode         (stallDecode),
    .flushDecode         (flushDecode),
    .bubbleExecute       (bubbleExecute),
    .rs1ForwardSel       (rs1ForwardSel),
    .rs2ForwardSel       (rs2ForwardSel),
    .perf_stallCycles    (perf_stallCycles)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    decode_valid = 1'b1;
    decode_rs1Addr = rs1; decode_rs1Used = u1;
    decode_rs2Addr = rs2; decode_rs2Used = u2;
    decode_rdAddr = rd; decode_rdWriteEnable = we; decode_isLoad = ld;
  endtask

  task automatic set_nop();
    set_instr('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    decode_valid = 1'b0;
  endtask

  task automatic drain();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    repeat (2) tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", ctrl); end
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL reset_sels: got %b want 0000", sels); end
    n_cmp++; if (perf_stallCycles !== 32'd0) begin n_err++; $display("FAIL reset_perf: got %0d want 0", perf_stallCycles); end
    set_nop();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_e();
    drain();
    set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL alu_e_prod_ctrl: got %b want 0000", ctrl); end
    tick();
    set_instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL alu_e_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0100) begin n_err++; $display("FAIL alu_e_sels: got %b want 0100", sels); end
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL alu_e_stall1: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL alu_e_stall2: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL alu_e_release: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL alu_e_sels: got %b want 0000", sels); end
    exp_perf += 32'd2;
`endif
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL alu_e_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  task automatic test_alu_m();
    drain();
    set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_nop();
    tick();
    set_instr(5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL alu_m_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0010) begin n_err++; $display("FAIL alu_m_sels: got %b want 0010", sels); end
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL alu_m_stall: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL alu_m_release: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL alu_m_sels: got %b want 0000", sels); end
    exp_perf += 32'd1;
`endif
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL alu_m_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  task automatic test_load_use();
    drain();
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_instr(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL lu_stall: got %b want 1101", ctrl); end
    tick();
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL lu_release: got %b want 0000", ctrl); end
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL lu_bubble_sels: got %b want 0000", sels); end
    tick();
    n_cmp++; if (sels !== 4'b1010) begin n_err++; $display("FAIL lu_sels: got %b want 1010", sels); end
    exp_perf += 32'd1;
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL lu_stall2: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL lu_release: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL lu_sels: got %b want 0000", sels); end
    exp_perf += 32'd2;
`endif
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL lu_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  task automatic test_masked();
    drain();
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL x0_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL x0_sels: got %b want 0000", sels); end
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    tick();
    set_instr(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL nowe_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL nowe_sels: got %b want 0000", sels); end
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    decode_valid = 1'b0;
    tick();
    set_instr(5'd10, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL bubble_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL bubble_sels: got %b want 0000", sels); end
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL masked_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  task automatic test_branch_load_use();
    drain();
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_instr(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    execute_branchTaken = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 4'b0011) begin n_err++; $display("FAIL br_ctrl: got %b want 0011", ctrl); end
    tick();
    execute_branchTaken = 1'b0;
    #1;
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL br_bubble_sels: got %b want 0000", sels); end
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL br_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL br_after_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b1010) begin n_err++; $display("FAIL br_after_sels: got %b want 1010", sels); end
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL br_after_stall: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL br_after_release: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL br_after_sels: got %b want 0000", sels); end
    exp_perf += 32'd1;
`endif
  endtask

  task automatic test_back_to_back();
    drain();
    set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL b2b_second_ctrl: got %b want 0000", ctrl); end
    tick();
    set_instr(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL b2b_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0101) begin n_err++; $display("FAIL b2b_sels: got %b want 0101", sels); end
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL b2b_stall1: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL b2b_stall2: got %b want 1101", ctrl); end
    tick();
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL b2b_release: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL b2b_sels: got %b want 0000", sels); end
    exp_perf += 32'd2;
`endif
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL b2b_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_instr(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1101", ctrl); end
    tick();
    exp_perf += 32'd1;
`ifdef JZJPCC_FORWARDING_EN
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL rst_in_loadstall: got %b want 0000", ctrl); end
`else
    n_cmp++; if (ctrl !== 4'b1101) begin n_err++; $display("FAIL rst_in_stall: got %b want 1101", ctrl); end
`endif
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL rst_pre_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
    #2;
    reset_n = 1'b0;
    #1;
    exp_perf = '0;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL rst_async_ctrl: got %b want 0000", ctrl); end
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL rst_async_sels: got %b want 0000", sels); end
    n_cmp++; if (perf_stallCycles !== 32'd0) begin n_err++; $display("FAIL rst_async_perf: got %0d want 0", perf_stallCycles); end
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 4'b0000) begin n_err++; $display("FAIL rst_release_ctrl: got %b want 0000", ctrl); end
    tick();
    n_cmp++; if (sels !== 4'b0000) begin n_err++; $display("FAIL rst_release_sels: got %b want 0000", sels); end
    n_cmp++; if (perf_stallCycles !== exp_perf) begin n_err++; $display("FAIL rst_release_perf: got %0d want %0d", perf_stallCycles, exp_perf); end
  endtask

  initial begin
    test_reset();
    test_alu_e();
    test_alu_m();
    test_load_use();
    test_masked();
    test_branch_load_use();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
